// File: rtl/ifetch_unit.sv
// ifetch_unit: ROM fetch front end, 2 cycles from address to INST_VALID, one skid entry absorbs back-pressure.
// Optional IFETCH_MISALIGN_TRAP_EN: a misaligned redirect emits one INST_MISALIGN beat, then fetch stalls.
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] IMEM_A,
  input  logic [XLEN-1:0] IMEM_RD,
  output logic            INST_VALID,
  input  logic            INST_READY,
  output logic [XLEN-1:0] INST,
  output logic [XLEN-1:0] INST_PC,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic            INST_MISALIGN,
`endif
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC
);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

  logic [XLEN-1:0] pc_q, inflight_pc, skid_inst, skid_pc, out_inst, out_pc;
  logic            inflight_v, skid_v, out_v;
  logic            slot_free, issue_ok, fetch, trap_pend, stall;
  logic            skid_to_out, ret_to_out, ret_to_skid;
  logic [XLEN-1:0] ret_inst, redirect_pc_eff;

  assign IMEM_A     = pc_q & ~LOW_MASK;
  assign INST_VALID = out_v;
  assign INST       = out_inst;
  assign INST_PC    = out_pc;

  assign slot_free = !out_v || INST_READY;
  // Issue only when the skid is certain to be empty next cycle, so the returning word always has a home
  // and a drain cycle can overlap the next fetch without a bubble.
  assign issue_ok    = !REDIRECT && !stall && (slot_free || (!skid_v && !inflight_v));
  assign fetch       = issue_ok && !trap_pend;
  assign skid_to_out = skid_v && slot_free;
  assign ret_to_out  = inflight_v && !skid_v && slot_free;
  assign ret_to_skid = inflight_v && !skid_v && !slot_free;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic inflight_mis, skid_mis, out_mis, trap_q, stall_q;

  assign trap_pend       = trap_q;
  assign stall           = stall_q;
  assign ret_inst        = inflight_mis ? '0 : IMEM_RD;
  assign redirect_pc_eff = REDIRECT_PC;
  assign INST_MISALIGN   = out_v && out_mis;

  // The trap beat rides the normal inflight/skid/out path with a zero word and the unmasked PC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      trap_q       <= 1'b0;
      stall_q      <= 1'b0;
      inflight_mis <= 1'b0;
      skid_mis     <= 1'b0;
      out_mis      <= 1'b0;
    end else if (REDIRECT) begin
      trap_q       <= |REDIRECT_PC[1:0];
      stall_q      <= 1'b0;
      inflight_mis <= 1'b0;
      skid_mis     <= 1'b0;
      out_mis      <= 1'b0;
    end else begin
      if (issue_ok && trap_q) begin
        trap_q  <= 1'b0;
        stall_q <= 1'b1;
      end
      inflight_mis <= issue_ok && trap_q;
      if (skid_to_out)     out_mis <= skid_mis;
      else if (ret_to_out) out_mis <= inflight_mis;
      if (ret_to_skid)     skid_mis <= inflight_mis;
    end
  end
`else
  assign trap_pend       = 1'b0;
  assign stall           = 1'b0;
  assign ret_inst        = IMEM_RD;
  assign redirect_pc_eff = REDIRECT_PC & ~LOW_MASK;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
      skid_v      <= 1'b0;
      skid_inst   <= '0;
      skid_pc     <= '0;
      out_v       <= 1'b0;
      out_inst    <= '0;
      out_pc      <= '0;
    end else if (REDIRECT) begin
      pc_q       <= redirect_pc_eff;
      inflight_v <= 1'b0;
      skid_v     <= 1'b0;
      out_v      <= 1'b0;
    end else begin
      inflight_v <= issue_ok;
      if (issue_ok) inflight_pc <= pc_q;
      if (fetch)    pc_q <= pc_q + XLEN'(4);

      if (skid_to_out) begin
        out_v    <= 1'b1;
        out_inst <= skid_inst;
        out_pc   <= skid_pc;
        skid_v   <= 1'b0;
      end else if (ret_to_out) begin
        out_v    <= 1'b1;
        out_inst <= ret_inst;
        out_pc   <= inflight_pc;
      end else begin
        if (ret_to_skid) begin
          skid_v    <= 1'b1;
          skid_inst <= ret_inst;
          skid_pc   <= inflight_pc;
        end
        if (slot_free) out_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized ready/redirect run against a program-order model.
`timescale 1ns/1ps
module tb_ifetch_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] a0, rd0, inst0, pc0;
  logic [31:0] a1, rd1, inst1, pc1;
  logic        v0, v1;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        mis0, mis1;
`endif
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0010_0093;
      32'h4:   rom = 32'h0010_0113;
      32'h8:   rom = 32'h0020_81b3;
      default: rom = a ^ {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    rd0 <= rom(a0);
    rd1 <= rom(a1);
  end

  ifetch_unit u0 (
    .CLK(clk), .RST(rst), .IMEM_A(a0), .IMEM_RD(rd0), .INST_VALID(v0), .INST_READY(ready),
    .INST(inst0), .INST_PC(pc0),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .INST_MISALIGN(mis0),
`endif
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc));

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .CLK(clk), .RST(rst), .IMEM_A(a1), .IMEM_RD(rd1), .INST_VALID(v1), .INST_READY(ready),
    .INST(inst1), .INST_PC(pc1),
`ifdef IFETCH_MISALIGN_TRAP_EN
    .INST_MISALIGN(mis1),
`endif
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle with RST low.
  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", v0); end
    tests++; if (a0 !== 32'h0) begin fails++; $display("FAIL reset_imem_a: got %h exp 0", a0); end
    tests++; if (inst0 !== 32'h0 || pc0 !== 32'h0) begin fails++; $display("FAIL reset_out: got inst %h pc %h exp 0 0", inst0, pc0); end
    tests++; if (a1 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL reset_pc_param: got %h exp fffffff8", a1); end
  endtask

  task automatic test_stream();
    logic [31:0] words [3] = '{32'h0010_0093, 32'h0010_0113, 32'h0020_81b3};
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) begin
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL stream_latency c%0d: got valid %b exp 0", c, v0); end
      end else begin
        tests++;
        if (v0 !== 1'b1 || pc0 !== 32'((c - 2) * 4) || inst0 !== words[c-2]) begin
          fails++; $display("FAIL stream_beat c%0d: got v%b pc %h inst %h exp v1 pc %h inst %h", c, v0, pc0, inst0, 32'((c - 2) * 4), words[c-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (v0 !== 1'b1 || pc0 !== 32'h4 || inst0 !== 32'h0010_0113) begin
        fails++; $display("FAIL bp_hold k%0d: got v%b pc %h inst %h exp v1 pc 4 inst 00100113", k, v0, pc0, inst0);
      end
      tests++; if (a0 !== 32'hC) begin fails++; $display("FAIL bp_imem_a k%0d: got %h exp c", k, a0); end
      tick();
    end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (v0 !== 1'b1 || pc0 !== 32'(4 + 4 * k) || inst0 !== rom(32'(4 + 4 * k))) begin
        fails++; $display("FAIL bp_resume k%0d: got v%b pc %h inst %h exp v1 pc %h", k, v0, pc0, inst0, 32'(4 + 4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    tests++; if (v0 !== 1'b1 || pc0 !== 32'h14) begin fails++; $display("FAIL redir_pre: got v%b pc %h exp v1 pc 14", v0, pc0); end
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0; ready = 1'b1;
    tests++; if (v0 !== 1'b0 || a0 !== 32'h0) begin fails++; $display("FAIL redir_c0: got v%b a %h exp v0 a 0", v0, a0); end
    tick();
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL redir_c1: got v%b exp 0", v0); end
    tick();
    tests++; if (v0 !== 1'b1 || pc0 !== 32'h0 || inst0 !== 32'h0010_0093) begin fails++; $display("FAIL redir_c2: got v%b pc %h inst %h exp v1 pc 0 inst 00100093", v0, pc0, inst0); end
    tick();
    tests++; if (v0 !== 1'b1 || pc0 !== 32'h4) begin fails++; $display("FAIL redir_c3: got v%b pc %h exp v1 pc 4", v0, pc0); end
  endtask

  task automatic test_redirect_skid();
    do_reset();
    ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; ready = 1'b1;
    tests++; if (a0 !== 32'h40 || v0 !== 1'b0) begin fails++; $display("FAIL rskid_c0: got a %h v%b exp a 40 v0", a0, v0); end
    tick();
    tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL rskid_c1: got v%b exp 0", v0); end
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (v0 !== 1'b1 || pc0 !== 32'(32'h40 + 4 * k) || inst0 !== rom(32'(32'h40 + 4 * k))) begin
        fails++; $display("FAIL rskid_beat k%0d: got v%b pc %h inst %h exp pc %h", k, v0, pc0, inst0, 32'(32'h40 + 4 * k));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    do_reset();
    ready = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (v1 !== 1'b1 || pc1 !== pcs[k] || inst1 !== rom(pcs[k])) begin
        fails++; $display("FAIL wrap k%0d: got v%b pc %h inst %h exp pc %h inst %h", k, v1, pc1, inst1, pcs[k], rom(pcs[k]));
      end
      tick();
    end
  endtask

  task automatic test_misalign();
    do_reset();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    tick(); tick();
    tests++;
    if (v0 !== 1'b1 || pc0 !== 32'h6 || inst0 !== 32'h0 || mis0 !== 1'b1) begin
      fails++; $display("FAIL mis_beat: got v%b pc %h inst %h mis %b exp v1 pc 6 inst 0 mis 1", v0, pc0, inst0, mis0);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL mis_stall k%0d: got v%b exp 0", k, v0); end
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    tick(); tick();
    tests++;
    if (v0 !== 1'b1 || pc0 !== 32'h8 || inst0 !== 32'h0020_81b3 || mis0 !== 1'b0) begin
      fails++; $display("FAIL mis_recover: got v%b pc %h inst %h mis %b exp v1 pc 8 inst 002081b3 mis 0", v0, pc0, inst0, mis0);
    end
`else
    tests++; if (a0 !== 32'h4) begin fails++; $display("FAIL mis_mask_a: got %h exp 4", a0); end
    tick(); tick();
    tests++; if (v0 !== 1'b1 || pc0 !== 32'h4 || inst0 !== 32'h0010_0113) begin fails++; $display("FAIL mis_mask_beat: got v%b pc %h inst %h exp v1 pc 4", v0, pc0, inst0); end
`endif
  endtask

  // Model: accepted beats form the program-order sequence from the latest restart point;
  // outputs hold while stalled; first beat after a restart appears exactly 2 cycles later.
  task automatic test_random();
    logic [31:0] exp_pc, rp, prev_pc, prev_inst;
    logic        hold_prev;
    int          age, beats;
    do_reset();
    exp_pc = 32'h0; age = 0; beats = 0; hold_prev = 1'b0; prev_pc = '0; prev_inst = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (age < 2) begin
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL rand_early cyc%0d: got v%b exp 0", cyc, v0); end
      end else if (age == 2) begin
        tests++; if (v0 !== 1'b1) begin fails++; $display("FAIL rand_latency cyc%0d: got v%b exp 1", cyc, v0); end
      end
      if (hold_prev) begin
        tests++;
        if (v0 !== 1'b1 || pc0 !== prev_pc || inst0 !== prev_inst) begin
          fails++; $display("FAIL rand_hold cyc%0d: got v%b pc %h inst %h exp v1 pc %h inst %h", cyc, v0, pc0, inst0, prev_pc, prev_inst);
        end
      end
      ready = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 29) == 0);
      rp = $urandom & 32'h0000_FFFF;
`ifdef IFETCH_MISALIGN_TRAP_EN
      rp = rp & ~32'h3;
`endif
      redirect_pc = rp;
      if (v0 && ready) begin
        tests++;
        if (pc0 !== exp_pc || inst0 !== rom(exp_pc)) begin
          fails++; $display("FAIL rand_beat cyc%0d: got pc %h inst %h exp pc %h inst %h", cyc, pc0, inst0, exp_pc, rom(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        beats++;
      end
      hold_prev = v0 && !ready && !redirect;
      prev_pc = pc0; prev_inst = inst0;
      if (redirect) begin
        exp_pc = rp & ~32'h3;
        age = 0;
      end else if (age < 100) begin
        age++;
      end
      tick();
    end
    redirect = 1'b0;
    tests++; if (beats < 500) begin fails++; $display("FAIL rand_progress: got %0d beats exp >= 500", beats); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_skid();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule
